ahb_interconnect: RTL and testbench

Parametrised single-master AHB-Lite interconnect: address decoder, data-phase response multiplexer and built-in default slave in one block. It sits between one AHB master and NUM_SLAVES slaves and replaces the separate fixed 4-slave decoder/mux pair. Slave selection comes from the address rather than a side-band select. Unmapped or out-of-range accesses receive a protocol-correct two-cycle ERROR response.

---
 rtl/ahb_interconnect_if.sv | 32 +++
 rtl/ahb_interconnect.sv | 135 +++++++++++++
 tb/tb_ahb_interconnect.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_interconnect_if.sv
// AHB-Lite bus bundle between one master (plus its attached slaves) and ahb_interconnect.
//   master modport : bus-facing side; drives address phase and slave responses,
//                    observes selects and the muxed response.
//   slave  modport : the interconnect's view; decodes the address, muxes the data phase.
// Signals: haddr, htrans, hwrite (master), hsel_s (one-hot selects), hready/hresp/hrdata
// (muxed to master, hready also broadcast to slaves), hrdata_s/hreadyout_s/hresp_s (slaves).
interface ahb_interconnect_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  logic [ADDR_W-1:0]            haddr;
  logic [1:0]                   htrans;
  logic                         hwrite;
  logic [NUM_SLAVES-1:0]        hsel_s;
  logic                         hready;
  logic                         hresp;
  logic [DATA_W-1:0]            hrdata;
  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s;
  logic [NUM_SLAVES-1:0]        hreadyout_s;
  logic [NUM_SLAVES-1:0]        hresp_s;

  modport master (
    output haddr, htrans, hwrite, hrdata_s, hreadyout_s, hresp_s,
    input  hsel_s, hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hrdata_s, hreadyout_s, hresp_s,
    output hsel_s, hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: region address decoder, registered data-phase
// response mux and a built-in default slave that answers unmapped regions with a
// two-cycle ERROR.
// Ports:
//   hclk, hresetn : bus clock, asynchronous active-low reset
//   bus           : ahb_interconnect_if.slave (address phase in, selects and muxed response out)
//   err_count     : saturating ERROR-response count      (only with AHB_ERRLOG_EN)
//   err_addr      : address of the latest ERROR transfer (only with AHB_ERRLOG_EN)
// Optional feature macro: AHB_ERRLOG_EN (error logging ports and registers).
module ahb_interconnect #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REGION_W   = 4
) (
  input  logic                hclk,
  input  logic                hresetn,
  ahb_interconnect_if.slave   bus
`ifdef AHB_ERRLOG_EN
  ,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   err_addr
`endif
);

  // Target encoding: 0..NUM_SLAVES-1 = slave, then DEF, then NONE.
  localparam int unsigned    SelW    = $clog2(NUM_SLAVES + 2);
  localparam logic [SelW-1:0] SelDef  = SelW'(NUM_SLAVES);
  localparam logic [SelW-1:0] SelNone = SelW'(NUM_SLAVES + 1);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} dflt_state_e;

  logic [REGION_W-1:0]   region;
  logic [NUM_SLAVES-1:0] hsel;
  logic [SelW-1:0]       addr_tgt;
  logic [SelW-1:0]       dsel_d, dsel_q;
  dflt_state_e           st_d, st_q;
  logic                  dflt_ready, dflt_resp;
  logic                  err_start;
  logic                  hready, hresp;
  logic [DATA_W-1:0]     hrdata;

  assign region = bus.haddr[ADDR_W-1 -: REGION_W];

  // Address decode depends on haddr only; htrans does not gate the selects.
  always_comb begin
    hsel     = '0;
    addr_tgt = SelDef;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (32'(region) == i) begin
        hsel[i]  = 1'b1;
        addr_tgt = SelW'(i);
      end
    end
  end

  assign bus.hsel_s = hsel;

  // An active (NONSEQ/SEQ) transfer to the default slave accepted this cycle.
  assign err_start = hready && (addr_tgt == SelDef) && bus.htrans[1];

  assign dsel_d = hready ? addr_tgt : dsel_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel_q <= SelNone;
      st_q   <= StIdle;
    end else begin
      dsel_q <= dsel_d;
      st_q   <= st_d;
    end
  end

  // Default-slave outputs come straight from the state so hready has no loop through st_d.
  assign dflt_ready = (st_q != StErr1);
  assign dflt_resp  = (st_q != StIdle);

  always_comb begin
    st_d = st_q;
    case (st_q)
      StIdle:  if (err_start) st_d = StErr1;
      StErr1:  st_d = StErr2;
      StErr2:  st_d = err_start ? StErr1 : StIdle;
      default: st_d = StIdle;
    endcase
  end

  // Data-phase response mux; NONE (after reset) answers zero-wait OKAY.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (dsel_q == SelDef) begin
      hready = dflt_ready;
      hresp  = dflt_resp;
    end
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q == SelW'(i)) begin
        hready = bus.hreadyout_s[i];
        hresp  = bus.hresp_s[i];
        hrdata = bus.hrdata_s[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.hready = hready;
  assign bus.hresp  = hresp;
  assign bus.hrdata = hrdata;

`ifdef AHB_ERRLOG_EN
  logic [ADDR_W-1:0] haddr_q;
  logic [15:0]       err_count_q;
  logic [ADDR_W-1:0] err_addr_q;

  // hresp=1 with hready=0 marks the first cycle of any two-cycle ERROR response,
  // whether it comes from the default slave (ERR1) or from a real slave.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr_q     <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      if (hready) haddr_q <= bus.haddr;
      if (hresp && !hready) begin
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        err_addr_q <= haddr_q;
      end
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_ahb_interconnect.sv
module tb_ahb_interconnect;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  ahb_interconnect_if #(.NUM_SLAVES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef AHB_ERRLOG_EN
  logic [15:0]   err_count;
  logic [AW-1:0] err_addr;
`endif

  ahb_interconnect #(
    .NUM_SLAVES(N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .REGION_W  (4)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
`ifdef AHB_ERRLOG_EN
    ,
    .err_count(err_count),
    .err_addr (err_addr)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mdl_tgt: -2 nothing in data phase, -1 default slave, >=0 slave index.
  // mdl_err: ERROR cycles still to deliver for the current default-slave data phase.
  int            mdl_tgt = -2;
  int            mdl_err = 0;
  logic [AW-1:0] mdl_addr = '0;
  int unsigned   mdl_cnt = 0;
  logic [AW-1:0] mdl_eaddr = '0;

  function automatic int decode(input logic [AW-1:0] a);
    int r;
    r = int'(a[AW-1 -: 4]);
    return (r < int'(N)) ? r : -1;
  endfunction

  initial begin : compare
    logic          e_rdy, e_rsp;
    logic [DW-1:0] e_dat;
    logic [N-1:0]  e_sel;
    int            t;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        mdl_tgt = -2; mdl_err = 0; mdl_addr = '0; mdl_cnt = 0; mdl_eaddr = '0;
      end
      e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
      if (mdl_tgt >= 0) begin
        e_rdy = bus.hreadyout_s[mdl_tgt];
        e_rsp = bus.hresp_s[mdl_tgt];
        e_dat = bus.hrdata_s[mdl_tgt*DW +: DW];
      end else if (mdl_tgt == -1) begin
        e_rdy = (mdl_err != 2);
        e_rsp = (mdl_err > 0);
      end
      e_sel = '0;
      t = decode(bus.haddr);
      if (t >= 0) e_sel[t] = 1'b1;
      chk("hsel_s", 64'(bus.hsel_s), 64'(e_sel));
      chk("hready", 64'(bus.hready), 64'(e_rdy));
      chk("hresp", 64'(bus.hresp), 64'(e_rsp));
      chk("hrdata", 64'(bus.hrdata), 64'(e_dat));
`ifdef AHB_ERRLOG_EN
      chk("err_count", 64'(err_count), 64'(mdl_cnt));
      chk("err_addr", 64'(err_addr), 64'(mdl_eaddr));
`endif
      @(posedge hclk);
      if (hresetn) begin
        if (e_rsp && !e_rdy) begin
          if (mdl_cnt < 32'hFFFF) mdl_cnt++;
          mdl_eaddr = mdl_addr;
        end
        if (e_rdy) begin
          t = decode(bus.haddr);
          mdl_tgt  = t;
          mdl_err  = (t == -1 && bus.htrans[1]) ? 2 : 0;
          mdl_addr = bus.haddr;
        end else if (mdl_err > 0) begin
          mdl_err--;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [1:0] tr);
    bus.haddr  = a;
    bus.htrans = tr;
    bus.hwrite = 1'b0;
  endtask

  task automatic pulse_reset();
    hresetn = 1'b0;
    @(negedge hclk);
    #1 hresetn = 1'b1;
  endtask

  initial begin : stim
    bus.haddr       = 32'hF000_0000;
    bus.htrans      = 2'd0;
    bus.hwrite      = 1'b0;
    bus.hrdata_s    = '0;
    bus.hreadyout_s = '1;
    bus.hresp_s     = '0;

    // Reset state
    #12;
    chk("rst_hready", 64'(bus.hready), 64'd1);
    chk("rst_hresp", 64'(bus.hresp), 64'd0);
    chk("rst_hrdata", 64'(bus.hrdata), 64'd0);
    chk("rst_hsel", 64'(bus.hsel_s), 64'd0);
`ifdef AHB_ERRLOG_EN
    chk("rst_err_count", 64'(err_count), 64'd0);
`endif
    @(negedge hclk);
    #1 hresetn = 1'b1;

    // Mapped read to slave 2
    tick();
    drive(32'h2000_0010, 2'd2);
    bus.hrdata_s[2*DW +: DW] = 32'hCAFE_F00D;
    @(negedge hclk);
    chk("rd_hsel", 64'(bus.hsel_s), 64'b0100);
    tick();
    drive(32'h0000_0000, 2'd0);
    @(negedge hclk);
    chk("rd_hrdata", 64'(bus.hrdata), 64'hCAFE_F00D);
    chk("rd_hready", 64'(bus.hready), 64'd1);
    chk("rd_hresp", 64'(bus.hresp), 64'd0);

    // Wait states from slave 1, next address phase to slave 3 held off
    tick();
    drive(32'h1000_0000, 2'd2);
    bus.hrdata_s[1*DW +: DW] = 32'h1111_1111;
    tick();
    drive(32'h3000_0000, 2'd2);
    bus.hreadyout_s[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      chk("ws_hready", 64'(bus.hready), 64'd0);
      chk("ws_hrdata", 64'(bus.hrdata), 64'h1111_1111);
      chk("ws_hsel", 64'(bus.hsel_s), 64'b1000);
      tick();
    end
    bus.hreadyout_s[1] = 1'b1;
    bus.hrdata_s[3*DW +: DW] = 32'h3333_3333;
    @(negedge hclk);
    chk("ws_release", 64'(bus.hready), 64'd1);
    tick();
    drive(32'h0000_0000, 2'd0);
    @(negedge hclk);
    chk("ws_slave3", 64'(bus.hrdata), 64'h3333_3333);

    // Unmapped NONSEQ then IDLE to the same region
    tick();
    drive(32'h9000_0000, 2'd2);
    @(negedge hclk);
    chk("um_hsel", 64'(bus.hsel_s), 64'd0);
    tick();
    drive(32'h9000_0000, 2'd0);
    @(negedge hclk);
    chk("um_err1", 64'({bus.hready, bus.hresp}), 64'b01);
    tick();
    @(negedge hclk);
    chk("um_err2", 64'({bus.hready, bus.hresp}), 64'b11);
    tick();
    @(negedge hclk);
    chk("um_idle_okay", 64'({bus.hready, bus.hresp}), 64'b10);
    tick();
    drive(32'h0000_0000, 2'd0);

    // Back-to-back errors from a clean reset
    pulse_reset();
    tick();
    drive(32'h9000_0000, 2'd2);
    tick();
    drive(32'hA000_0004, 2'd2);
    @(negedge hclk);
    chk("bb_a_err1", 64'({bus.hready, bus.hresp}), 64'b01);
    tick();
    @(negedge hclk);
    chk("bb_a_err2", 64'({bus.hready, bus.hresp}), 64'b11);
    tick();
    drive(32'h0000_0000, 2'd0);
    @(negedge hclk);
    chk("bb_b_err1", 64'({bus.hready, bus.hresp}), 64'b01);
    tick();
    @(negedge hclk);
    chk("bb_b_err2", 64'({bus.hready, bus.hresp}), 64'b11);
    tick();
    @(negedge hclk);
    chk("bb_okay", 64'({bus.hready, bus.hresp}), 64'b10);
`ifdef AHB_ERRLOG_EN
    chk("bb_err_count", 64'(err_count), 64'd2);
    chk("bb_err_addr", 64'(err_addr), 64'hA000_0004);
`endif

    // Reset asserted during ERR1
    tick();
    drive(32'h9000_0000, 2'd2);
    tick();
    drive(32'h0000_0000, 2'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("mid_rst_hready", 64'(bus.hready), 64'd1);
    chk("mid_rst_hresp", 64'(bus.hresp), 64'd0);
    @(negedge hclk);
    #1 hresetn = 1'b1;
    tick();
    drive(32'h0000_0004, 2'd2);
    bus.hrdata_s[0*DW +: DW] = 32'h0BAD_BEEF;
    tick();
    drive(32'h0000_0000, 2'd0);
    @(negedge hclk);
    chk("post_rst_rd", 64'({bus.hready, bus.hresp, bus.hrdata}), {30'd0, 2'b10, 32'h0BAD_BEEF});

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      tick();
      bus.haddr  = $urandom();
      bus.htrans = 2'($urandom_range(0, 3));
      bus.hwrite = 1'($urandom_range(0, 1));
      for (int s = 0; s < int'(N); s++) begin
        bus.hrdata_s[s*DW +: DW] = $urandom();
        bus.hreadyout_s[s]       = ($urandom_range(0, 3) != 0);
        bus.hresp_s[s]           = ($urandom_range(0, 7) == 0);
      end
    end
    tick();
    @(negedge hclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
